// File: rtl/weight_rom_stream_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// weight_sched_pkg
// Shared types and helpers for the weight ROM stream scheduler.
//   state_t    : sequencer states (IDLE / STREAM / DRAIN)
//   inflight_t : one slot of the ROM read-latency tracker {valid, last, id}
//   rr_pick    : round-robin winner search starting at a pointer
// ---------------------------------------------------------------------------
package weight_sched_pkg;

    // Upper bounds that size the shared types; the top checks its
    // parameters against them at elaboration.
    localparam int SCHED_MAX_REQ = 32;
    localparam int SCHED_ID_W    = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [SCHED_ID_W-1:0] id;
    } inflight_t;

    // Returns the index of the first set bit of req[0..n-1] at or after ptr,
    // searching circularly. The caller forms the one-hot grant from it and
    // only uses the result when req is non-zero. Iterating from the far end
    // lets the nearest candidate overwrite the others.
    function automatic int rr_pick(input logic [SCHED_MAX_REQ-1:0] req,
                                   input int n,
                                   input int ptr);
        int idx;
        int win;
        win = 0;
        for (int k = SCHED_MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx]) win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/weight_rom_stream_scheduler_if.sv
// ---------------------------------------------------------------------------
// weight_rom_stream_scheduler_if
// Bundles the requester, ROM and output-stream signals of the scheduler.
//   req/grant          : requester level requests and one-hot owner
//   rom_addr/rom_ce    : ROM read issue,  rom_q : ROM read data
//   data_out*          : valid/ready weight stream tagged with id and last
//   done/busy          : sweep completion pulse and activity flag
// master = scheduler side, slave = requesters/ROM/consumer side.
// ---------------------------------------------------------------------------
interface weight_rom_stream_scheduler_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = $clog2(576) + 1,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    grant;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_ce;
    logic [DATA_WIDTH-1:0] rom_q;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ID_WIDTH-1:0]   data_out_id;
    logic                  data_out_last;
    logic                  data_out_valid;
    logic                  data_out_ready;
    logic                  done;
    logic                  busy;

    modport master (
        input  req, rom_q, data_out_ready,
        output grant, rom_addr, rom_ce, data_out, data_out_id,
               data_out_last, data_out_valid, done, busy
    );

    modport slave (
        output req, rom_q, data_out_ready,
        input  grant, rom_addr, rom_ce, data_out, data_out_id,
               data_out_last, data_out_valid, done, busy
    );
endinterface

// File: rtl/weight_rom_stream_scheduler_fifo.sv
// ---------------------------------------------------------------------------
// weight_sched_fifo
// First-word-fall-through FIFO holding {id, last, data} beats.
//   i_clk, i_rst (sync, active low)
//   i_wr_en/i_wr_data : push
//   i_rd_en           : pop request (ignored when empty)
//   o_rd_data/o_valid : head entry, visible the cycle after it is written
//   o_count           : occupancy, used by the scheduler's credit check
// ---------------------------------------------------------------------------
module weight_sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_wr_en,
    input  logic [WIDTH-1:0]             i_wr_data,
    input  logic                         i_rd_en,
    output logic [WIDTH-1:0]             o_rd_data,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_pop     = i_rd_en && (r_count != '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_valid   = (r_count != '0);
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            // write and pop together leave the occupancy unchanged
            if (i_wr_en && !w_pop)      r_count <= r_count + CW'(1);
            else if (!i_wr_en && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // The upstream credit scheme must always leave room for a write.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(i_wr_en && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/weight_rom_stream_scheduler.sv
// ---------------------------------------------------------------------------
// weight_rom_stream_scheduler
// Shares one fixed-latency weight ROM read port among NUM_REQ consumers.
// A round-robin winner gets a full 0..DEPTH-1 sweep; reads are issued only
// while (in-flight + buffered) < FIFO_DEPTH so the output FIFO never
// overflows under backpressure.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-low reset
//   io_bus : master side of weight_rom_stream_scheduler_if
//            (req/grant, rom_addr/rom_ce/rom_q, data_out stream, done, busy)
// ---------------------------------------------------------------------------
module weight_rom_stream_scheduler
    import weight_sched_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 576,
    parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    weight_rom_stream_scheduler_if.master io_bus
);
    localparam int LAT = ROM_LATENCY;
    localparam int FW  = DATA_WIDTH + ID_WIDTH + 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < ROM_LATENCY + 1) begin : g_chk_fifo
        $error("FIFO_DEPTH must be at least ROM_LATENCY+1");
    end
    if (ROM_LATENCY < 1) begin : g_chk_lat
        $error("ROM_LATENCY must be at least 1");
    end
    if (NUM_REQ > SCHED_MAX_REQ || ID_WIDTH > SCHED_ID_W) begin : g_chk_req
        $error("NUM_REQ/ID_WIDTH exceed the package limits");
    end

    state_t                r_state, w_state_nxt;
    logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [ID_WIDTH-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [ID_WIDTH-1:0]   r_owner, w_owner_nxt;
    inflight_t             r_pipe [LAT];

    int                    w_win;
    int                    w_inflight;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_last_addr;
    logic                  w_pop;
    logic                  w_done;
    logic [CW-1:0]         w_fifo_count;
    logic [FW-1:0]         w_fifo_wdata;
    logic [FW-1:0]         w_fifo_rdata;
    logic                  w_fifo_valid;
    logic                  w_fifo_last;

    // ---------------- arbitration and credit ----------------
    always_comb begin
        w_win = rr_pick(SCHED_MAX_REQ'(io_bus.req), NUM_REQ, int'(r_rr_ptr));
    end

    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < LAT; i++) w_inflight = w_inflight + int'(r_pipe[i].valid);
    end

    // In-flight reads already own a FIFO slot, so this sum is the number of
    // entries the FIFO may yet have to absorb.
    assign w_credit_ok = (w_inflight + int'(w_fifo_count)) < FIFO_DEPTH;
    assign w_issue     = (r_state == STREAM) && w_credit_ok;
    assign w_last_addr = (r_cnt == ADDR_WIDTH'(DEPTH - 1));
    assign w_pop       = w_fifo_valid && io_bus.data_out_ready;
    assign w_fifo_last = w_fifo_rdata[DATA_WIDTH];

    // ---------------- sequencer ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_cnt_nxt    = r_cnt;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|io_bus.req) begin
                    w_state_nxt  = STREAM;
                    w_grant_nxt  = NUM_REQ'(1) << w_win;
                    w_owner_nxt  = ID_WIDTH'(w_win);
                    w_rr_ptr_nxt = (w_win == NUM_REQ - 1) ? '0 : ID_WIDTH'(w_win + 1);
                    w_cnt_nxt    = '0;
                end
            end
            STREAM: begin
                // the counter parks on DEPTH-1; DRAIN never issues
                if (w_issue) begin
                    if (w_last_addr) w_state_nxt = DRAIN;
                    else             w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (w_pop && w_fifo_last) begin
                    w_done      = 1'b1;
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- ROM latency tracker ----------------
    // Clearing this on reset is what drops ROM words still in the ROM pipe.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= '{valid: w_issue,
                           last:  w_issue && w_last_addr,
                           id:    SCHED_ID_W'(r_owner)};
            for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_fifo_wdata = {ID_WIDTH'(r_pipe[LAT-1].id), r_pipe[LAT-1].last, io_bus.rom_q};

    weight_sched_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (r_pipe[LAT-1].valid),
        .i_wr_data (w_fifo_wdata),
        .i_rd_en   (io_bus.data_out_ready),
        .o_rd_data (w_fifo_rdata),
        .o_valid   (w_fifo_valid),
        .o_count   (w_fifo_count)
    );

    // ---------------- outputs ----------------
    assign io_bus.grant          = r_grant;
    assign io_bus.rom_ce         = w_issue;
    assign io_bus.rom_addr       = (r_state == STREAM) ? r_cnt : '0;
    assign io_bus.data_out       = w_fifo_rdata[DATA_WIDTH-1:0];
    assign io_bus.data_out_last  = w_fifo_last;
    assign io_bus.data_out_id    = w_fifo_rdata[FW-1 -: ID_WIDTH];
    assign io_bus.data_out_valid = w_fifo_valid;
    assign io_bus.done           = w_done;
    assign io_bus.busy           = (r_state != IDLE);

endmodule

// File: tb/tb_weight_rom_stream_scheduler.sv
// ---------------------------------------------------------------------------
// tb_weight_rom_stream_scheduler
// Randomised bench with a transaction-level reference model (per-sweep beat
// queue, issue/accept counters, round-robin pointer) compared every cycle,
// plus directed scenarios with literal cycle/ID expectations.
// ---------------------------------------------------------------------------
module tb_weight_rom_stream_scheduler;
    localparam int NUM_REQ     = 3;
    localparam int DATA_WIDTH  = 128;
    localparam int DEPTH       = 8;
    localparam int ADDR_WIDTH  = $clog2(DEPTH) + 1;
    localparam int ROM_LATENCY = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int ID_WIDTH    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    weight_rom_stream_scheduler_if #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) bus ();

    weight_rom_stream_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH), .ROM_LATENCY(ROM_LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH), .ID_WIDTH(ID_WIDTH)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- ROM model ----------------
    logic [31:0] salt = 32'h0000_1000;
    function automatic logic [127:0] rom_word(input logic [31:0] s, input int a);
        return {s, ~s, 32'hC0DE_0000 ^ s, 32'(a)};
    endfunction

    logic                  l_ce;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [127:0]          rp [ROM_LATENCY];
    always @(negedge clk) begin
        l_ce   = bus.rom_ce;
        l_addr = bus.rom_addr;
    end
    always @(posedge clk) begin
        rp[0] <= l_ce ? rom_word(salt, int'(l_addr)) : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < ROM_LATENCY; i++) rp[i] <= rp[i-1];
    end
    assign bus.rom_q = rp[ROM_LATENCY-1];

    // ---------------- reference model + compare ----------------
    typedef struct {
        logic [127:0] d;
        int           id;
        logic         last;
    } beat_t;

    logic [NUM_REQ-1:0] m_grant = '0;
    int    m_rr = 0, m_issued = 0, m_acc = 0;
    int    m_iss_cyc [DEPTH];
    beat_t m_q [$];

    int done_cnt = 0, ce_cnt = 0, acc_cnt = 0;
    int done_ids [$];
    int rec_grant = -1, rec_valid = -1, rec_done = -1;
    logic [127:0] rec_first = '0, rec_last = '0;
    logic rec_first_set = 1'b0;

    always @(negedge clk) begin
        int   avail;
        int   w;
        logic acc;
        logic exp_ce;
        logic exp_valid;
        acc   = bus.data_out_valid && bus.data_out_ready;
        avail = 0;
        for (int i = 0; i < m_issued; i++)
            if (m_iss_cyc[i] + ROM_LATENCY + 1 <= cyc) avail++;
        exp_valid = (m_grant != '0) && (avail > m_acc);
        exp_ce    = (m_grant != '0) && (m_issued < DEPTH) && ((m_issued - m_acc) < FIFO_DEPTH);

        chk("grant", bus.grant, m_grant);
        chk("busy", bus.busy, m_grant != '0);
        chk("rom_ce", bus.rom_ce, exp_ce);
        if (m_grant == '0)          chk("rom_addr_idle", bus.rom_addr, 0);
        else if (m_issued < DEPTH)  chk("rom_addr", bus.rom_addr, m_issued);
        chk("valid", bus.data_out_valid, exp_valid);
        if (bus.data_out_valid) begin
            if (m_q.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
                chk("data", bus.data_out, m_q[0].d);
                chk("id", bus.data_out_id, m_q[0].id);
                chk("last", bus.data_out_last, m_q[0].last);
            end
        end
        chk("done", bus.done, acc && (m_acc == DEPTH - 1) && (m_grant != '0));

        // event log for directed checks
        if (bus.grant != '0 && rec_grant < 0) rec_grant = cyc;
        if (bus.data_out_valid && rec_valid < 0) rec_valid = cyc;
        if (bus.done) begin
            done_cnt++;
            done_ids.push_back(int'(bus.data_out_id));
            if (rec_done < 0) rec_done = cyc;
        end
        if (bus.rom_ce) ce_cnt++;
        if (acc) begin
            acc_cnt++;
            rec_last = bus.data_out;
            if (!rec_first_set) begin rec_first = bus.data_out; rec_first_set = 1'b1; end
        end

        // advance the model to the next cycle
        if (!rst) begin
            m_grant = '0; m_rr = 0; m_issued = 0; m_acc = 0;
            m_q.delete();
        end else if (m_grant != '0) begin
            if (bus.rom_ce && m_issued < DEPTH) begin
                m_iss_cyc[m_issued] = cyc;
                m_issued++;
            end
            if (acc) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                m_acc++;
                if (m_acc == DEPTH) m_grant = '0;
            end
        end else if (bus.req != '0) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++)
                if (w < 0 && bus.req[(m_rr + k) % NUM_REQ]) w = (m_rr + k) % NUM_REQ;
            m_grant  = NUM_REQ'(1) << w;
            m_rr     = (w + 1) % NUM_REQ;
            m_issued = 0;
            m_acc    = 0;
            for (int a = 0; a < DEPTH; a++) begin
                beat_t b;
                b.d = rom_word(salt, a); b.id = w; b.last = (a == DEPTH - 1);
                m_q.push_back(b);
            end
        end
    end

    // ---------------- stimulus ----------------
    int rdy_pct = 100;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle();
        bus.data_out_ready = ($urandom_range(1, 100) <= rdy_pct);
        step();
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            drive_cycle();
            n++;
        end
        if (done_cnt < target) chk("timeout_done", done_cnt, target);
    endtask

    task automatic clear_rec();
        rec_grant = -1; rec_valid = -1; rec_done = -1; rec_first_set = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, base, n, nd;
        bus.req            = '0;
        bus.data_out_ready = 1'b1;
        rst                = 1'b0;
        repeat (3) step();
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.data_out_valid, 0);
        chk("rst_rom_ce", bus.rom_ce, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b1;
        step();

        // directed latency / ordering sweep
        clear_rec();
        rdy_pct = 100;
        t0 = cyc;
        bus.req = 3'b001;
        drive_cycle();
        bus.req = '0;
        wait_done(1, 60);
        chk("t1_grant_cyc", rec_grant - t0, 1);
        chk("t1_valid_cyc", rec_valid - t0, 4);
        chk("t1_done_cyc", rec_done - t0, 11);
        chk("t1_first_word", rec_first[31:0], 0);
        chk("t1_last_word", rec_last[31:0], 7);
        chk("t1_id", done_ids[done_ids.size()-1], 0);

        // random stalls
        repeat (2) drive_cycle();
        rdy_pct = 50;
        base = acc_cnt;
        bus.req = 3'b001;
        wait_done(2, 200);
        bus.req = '0;
        chk("t2_beats", acc_cnt - base, DEPTH);

        // all requesting, from a fresh round-robin pointer
        rst = 1'b0; step(); rst = 1'b1;
        nd = done_ids.size();
        rdy_pct = 75;
        bus.req = 3'b111;
        wait_done(done_cnt + 4, 400);
        bus.req = '0;
        if (done_ids.size() >= nd + 4) begin
            chk("t3_order0", done_ids[nd],   0);
            chk("t3_order1", done_ids[nd+1], 1);
            chk("t3_order2", done_ids[nd+2], 2);
            chk("t3_order3", done_ids[nd+3], 0);
        end else chk("t3_sweeps", done_ids.size() - nd, 4);

        // single-cycle request pulse
        repeat (2) drive_cycle();
        rdy_pct = 60;
        bus.req = 3'b010;
        drive_cycle();
        bus.req = '0;
        wait_done(done_cnt + 1, 200);
        chk("t4_id", done_ids[done_ids.size()-1], 1);
        step();
        chk("t4_grant_clear", bus.grant, 0);

        // reset in the middle of a sweep
        rdy_pct = 100;
        base = acc_cnt;
        bus.req = 3'b001;
        n = 0;
        while (acc_cnt < base + 3 && n < 50) begin drive_cycle(); n++; end
        chk("t5_reach_beat3", (acc_cnt - base) >= 3, 1);
        rst = 1'b0;
        salt = salt + 32'h0000_0100;
        step();
        chk("t5_valid", bus.data_out_valid, 0);
        chk("t5_grant", bus.grant, 0);
        chk("t5_busy", bus.busy, 0);
        rst = 1'b1;
        clear_rec();
        bus.req = 3'b001;
        drive_cycle();
        bus.req = '0;
        wait_done(done_cnt + 1, 60);
        chk("t5_fresh_first", rec_first[31:0], 0);

        // consumer stalled from the start
        repeat (2) drive_cycle();
        rdy_pct = 0;
        base = ce_cnt;
        bus.req = 3'b001;
        drive_cycle();
        bus.req = '0;
        repeat (10) drive_cycle();
        chk("t6_issued_stalled", ce_cnt - base, FIFO_DEPTH);
        rdy_pct = 100;
        wait_done(done_cnt + 1, 60);
        chk("t6_total_issued", ce_cnt - base, DEPTH);

        // random traffic with occasional resets
        for (int it = 0; it < 30; it++) begin
            bus.req = NUM_REQ'($urandom_range(0, 7));
            rdy_pct = $urandom_range(20, 100);
            repeat ($urandom_range(1, 30)) drive_cycle();
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b0; drive_cycle(); rst = 1'b1;
            end
        end
        bus.req = '0;
        rdy_pct = 100;
        n = 0;
        while (bus.busy && n < 100) begin drive_cycle(); n++; end
        chk("final_idle", bus.busy, 0);
        repeat (3) drive_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
